// File: rtl/mult_pkg.sv
// Shared definitions for the parity-checked pipelined multiplier.
//   MULT_DATA_W : default operand width
//   hs_state_t  : request/acknowledge handshake FSM states
package mult_pkg;

    localparam int MULT_DATA_W = 16;

    typedef enum logic [1:0] {
        HS_IDLE     = 2'd0,
        HS_ACK      = 2'd1,
        HS_WAIT_LOW = 2'd2
    } hs_state_t;

endpackage : mult_pkg

// File: rtl/mult_parity_chk.sv
// Combinational operand parity check.
//   data   : operand bits
//   parity : parity supplied with the operand (correct when equal to ^data)
//   err    : 1 when the supplied parity disagrees with the operand
module mult_parity_chk
    import mult_pkg::*;
#(
    parameter int DATA_W = MULT_DATA_W
) (
    input  logic [DATA_W-1:0] data,
    input  logic              parity,
    output logic              err
);

    assign err = parity ^ (^data);

endmodule : mult_parity_chk

// File: rtl/mult_par_pipe.sv
// Pipelined, parity-checked multiplier with req/ack operand handshake.
//   clk, rst            : clock, asynchronous active-high reset
//   req                 : operand request, held by the source until ack
//   arg_a/arg_b         : operands, each with its own parity bit
//   ack                 : one-cycle acceptance pulse
//   result              : 2*DATA_W product (0 when an operand parity was wrong)
//   result_parity       : XOR of result bits
//   result_rdy          : one-cycle result-valid pulse, LAT = PIPE_STAGES+1
//   arg_parity_error    : error flag qualified by result_rdy
//   err_cnt             : saturating count of accepted errored requests
//   hs_state            : current handshake FSM state (debug visibility)
module mult_par_pipe
    import mult_pkg::*;
#(
    parameter int DATA_W      = MULT_DATA_W,
    parameter int PIPE_STAGES = 2,
    parameter bit SIGNED      = 1'b1,
    parameter int ERR_CNT_W   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req,
    input  logic [DATA_W-1:0]     arg_a,
    input  logic                  arg_a_parity,
    input  logic [DATA_W-1:0]     arg_b,
    input  logic                  arg_b_parity,
    output logic                  ack,
    output logic [2*DATA_W-1:0]   result,
    output logic                  result_parity,
    output logic                  result_rdy,
    output logic                  arg_parity_error,
    output logic [ERR_CNT_W-1:0]  err_cnt,
    output hs_state_t             hs_state
);

    localparam int PW = 2 * DATA_W;

    // Handshake: an operand pair is taken on the rising edge where req=1 and
    // the FSM is idle; ack is high for the following cycle. The source must
    // let req be sampled low once before the FSM will take another request,
    // so a request held high is never accepted twice.
    hs_state_t state_q, state_d;
    logic      accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= HS_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            HS_IDLE: begin
                if (req) begin
                    state_d = HS_ACK;
                    accept  = 1'b1;
                end
            end
            HS_ACK:      state_d = HS_WAIT_LOW;
            HS_WAIT_LOW: if (!req) state_d = HS_IDLE;
            default:     state_d = HS_IDLE;
        endcase
    end

    assign ack      = (state_q == HS_ACK);
    assign hs_state = state_q;

    // Parity is checked on the raw inputs so the error counter can update on
    // the accept edge itself.
    logic err_a, err_b, err_in;

    mult_parity_chk #(.DATA_W(DATA_W)) u_chk_a (
        .data   (arg_a),
        .parity (arg_a_parity),
        .err    (err_a)
    );

    mult_parity_chk #(.DATA_W(DATA_W)) u_chk_b (
        .data   (arg_b),
        .parity (arg_b_parity),
        .err    (err_b)
    );

    assign err_in = err_a | err_b;

    // Operand capture register
    logic              cap_v;
    logic              cap_err;
    logic [DATA_W-1:0] cap_a, cap_b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap_v   <= 1'b0;
            cap_err <= 1'b0;
            cap_a   <= '0;
            cap_b   <= '0;
        end else begin
            cap_v <= accept;
            if (accept) begin
                cap_err <= err_in;
                cap_a   <= arg_a;
                cap_b   <= arg_b;
            end
        end
    end

    // Error counter, saturating at all-ones
    logic [ERR_CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (accept && err_in && (err_cnt_q != {ERR_CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_cnt = err_cnt_q;

    // Both operands are extended to full product width so a single PW-bit
    // multiply yields the exact signed or unsigned product.
    logic [PW-1:0] ext_a, ext_b, product;

    always_comb begin
        if (SIGNED) begin
            ext_a = {{DATA_W{cap_a[DATA_W-1]}}, cap_a};
            ext_b = {{DATA_W{cap_b[DATA_W-1]}}, cap_b};
        end else begin
            ext_a = {{DATA_W{1'b0}}, cap_a};
            ext_b = {{DATA_W{1'b0}}, cap_b};
        end
        product = cap_err ? '0 : (ext_a * ext_b);
    end

    // Multiply pipeline: each stage carries valid, product and error flag.
    // Data registers load only with a valid beat; valids clear on reset so
    // in-flight operations are discarded.
    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        logic          v_d, e_d, v_q, e_q;
        logic [PW-1:0] p_d, p_q;

        if (i == 0) begin : g_first
            assign v_d = cap_v;
            assign e_d = cap_err;
            assign p_d = product;
        end else begin : g_next
            assign v_d = g_stage[i-1].v_q;
            assign e_d = g_stage[i-1].e_q;
            assign p_d = g_stage[i-1].p_q;
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v_q <= 1'b0;
                e_q <= 1'b0;
                p_q <= '0;
            end else begin
                v_q <= v_d;
                if (v_d) begin
                    e_q <= e_d;
                    p_q <= p_d;
                end
            end
        end
    end

    logic          last_v, last_e;
    logic [PW-1:0] last_p;

    assign last_v = g_stage[PIPE_STAGES-1].v_q;
    assign last_e = g_stage[PIPE_STAGES-1].e_q;
    assign last_p = g_stage[PIPE_STAGES-1].p_q;

    // Output register: result fields hold between result_rdy pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_rdy       <= 1'b0;
            result           <= '0;
            result_parity    <= 1'b0;
            arg_parity_error <= 1'b0;
        end else begin
            result_rdy <= last_v;
            if (last_v) begin
                result           <= last_p;
                result_parity    <= ^last_p;
                arg_parity_error <= last_e;
            end
        end
    end

endmodule : mult_par_pipe

// File: tb/tb_mult_par_pipe.sv
module tb_mult_par_pipe;
    import mult_pkg::*;

    logic clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    // Default instance: DATA_W=16, PIPE_STAGES=2, SIGNED=1, ERR_CNT_W=8
    logic        req;
    logic [15:0] a, b;
    logic        ap, bp;
    logic        ack, rpar, rdy, perr;
    logic [31:0] res;
    logic [7:0]  cnt;
    hs_state_t   st;

    // Narrow unsigned instance
    logic        req8;
    logic [7:0]  a8, b8;
    logic        ap8, bp8;
    logic        ack8, rpar8, rdy8, perr8;
    logic [15:0] res8;
    logic [7:0]  cnt8;
    hs_state_t   st8;

    // Small error counter instance
    logic        reqc;
    logic [15:0] ac, bc;
    logic        apc, bpc;
    logic        ackc, rparc, rdyc, perrc;
    logic [31:0] resc;
    logic [1:0]  cntc;
    hs_state_t   stc;

    mult_par_pipe dut (
        .clk(clk), .rst(rst), .req(req),
        .arg_a(a), .arg_a_parity(ap), .arg_b(b), .arg_b_parity(bp),
        .ack(ack), .result(res), .result_parity(rpar), .result_rdy(rdy),
        .arg_parity_error(perr), .err_cnt(cnt), .hs_state(st)
    );

    mult_par_pipe #(.DATA_W(8), .SIGNED(1'b0)) dut8 (
        .clk(clk), .rst(rst), .req(req8),
        .arg_a(a8), .arg_a_parity(ap8), .arg_b(b8), .arg_b_parity(bp8),
        .ack(ack8), .result(res8), .result_parity(rpar8), .result_rdy(rdy8),
        .arg_parity_error(perr8), .err_cnt(cnt8), .hs_state(st8)
    );

    mult_par_pipe #(.ERR_CNT_W(2)) dutc (
        .clk(clk), .rst(rst), .req(reqc),
        .arg_a(ac), .arg_a_parity(apc), .arg_b(bc), .arg_b_parity(bpc),
        .ack(ackc), .result(resc), .result_parity(rparc), .result_rdy(rdyc),
        .arg_parity_error(perrc), .err_cnt(cntc), .hs_state(stc)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One operation on the default instance; called at a negedge with the FSM
    // idle. Checks ack timing, the exact result_rdy cycle and the result.
    task automatic op16(input string tag,
                        input logic [15:0] ia, input logic iap,
                        input logic [15:0] ib, input logic ibp,
                        input logic [31:0] eres, input logic epar,
                        input logic eerr, input logic [7:0] ecnt);
        a = ia; ap = iap; b = ib; bp = ibp; req = 1'b1;
        @(negedge clk);                       // after accept edge T0
        chk({tag, " ack"}, ack, 1'b1);
        chk({tag, " cnt"}, cnt, ecnt);
        req = 1'b0;
        @(negedge clk);                       // after T0+1
        chk({tag, " ack_low"}, ack, 1'b0);
        chk({tag, " rdy_early1"}, rdy, 1'b0);
        @(negedge clk);                       // after T0+2
        chk({tag, " rdy_early2"}, rdy, 1'b0);
        @(negedge clk);                       // after T0+3
        chk({tag, " rdy"}, rdy, 1'b1);
        chk({tag, " result"}, res, eres);
        chk({tag, " rpar"}, rpar, epar);
        chk({tag, " perr"}, perr, eerr);
        @(negedge clk);                       // after T0+4
        chk({tag, " rdy_pulse"}, rdy, 1'b0);
        chk({tag, " result_hold"}, res, eres);
    endtask

    task automatic op8(input string tag,
                       input logic [7:0] ia, input logic [7:0] ib,
                       input logic [15:0] eres, input logic epar);
        a8 = ia; ap8 = ^ia; b8 = ib; bp8 = ^ib; req8 = 1'b1;
        @(negedge clk);
        chk({tag, " ack"}, ack8, 1'b1);
        req8 = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, " rdy"}, rdy8, 1'b1);
        chk({tag, " result"}, res8, eres);
        chk({tag, " rpar"}, rpar8, epar);
        chk({tag, " perr"}, perr8, 1'b0);
        @(negedge clk);
    endtask

    task automatic opc(input string tag,
                       input logic [15:0] ia, input logic iap,
                       input logic [15:0] ib, input logic ibp,
                       input logic [1:0] ecnt);
        ac = ia; apc = iap; bc = ib; bpc = ibp; reqc = 1'b1;
        @(negedge clk);
        chk({tag, " ack"}, ackc, 1'b1);
        chk({tag, " cnt"}, cntc, ecnt);
        reqc = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    logic [15:0] bb_a [3];
    logic [15:0] bb_b [3];
    logic [31:0] bb_exp [3];

    initial begin
        rst = 1'b1;
        req = 1'b0;  a = '0;  b = '0;  ap = 1'b0;  bp = 1'b0;
        req8 = 1'b0; a8 = '0; b8 = '0; ap8 = 1'b0; bp8 = 1'b0;
        reqc = 1'b0; ac = '0; bc = '0; apc = 1'b0; bpc = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst ack", ack, 1'b0);
        chk("rst result", res, 32'h0);
        chk("rst rpar", rpar, 1'b0);
        chk("rst rdy", rdy, 1'b0);
        chk("rst perr", perr, 1'b0);
        chk("rst cnt", cnt, 8'h0);
        chk("rst state", st, HS_IDLE);
        chk("rst cnt8", cnt8, 8'h0);
        chk("rst cntc", cntc, 2'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle state", st, HS_IDLE);
        chk("idle rdy", rdy, 1'b0);

        // 3 * -5 = -15; FFFFFFF1 has 29 ones -> parity 1
        op16("s3xm5", 16'h0003, 1'b0, 16'hFFFB, 1'b1, 32'hFFFF_FFF1, 1'b1, 1'b0, 8'd0);
        // Most negative squared: 0x4000_0000
        op16("min_sq", 16'h8000, 1'b1, 16'h8000, 1'b1, 32'h4000_0000, 1'b1, 1'b0, 8'd0);
        // 32767 * -32768 = 0xC000_8000 (3 ones)
        op16("max_min", 16'h7FFF, 1'b1, 16'h8000, 1'b1, 32'hC000_8000, 1'b1, 1'b0, 8'd0);
        // Wrong parity on A (7FFF has 15 ones, correct parity 1)
        op16("perr_a", 16'h7FFF, 1'b0, 16'h0002, 1'b1, 32'h0, 1'b0, 1'b1, 8'd1);
        // Both parities wrong
        op16("perr_ab", 16'h7FFF, 1'b0, 16'h0002, 1'b0, 32'h0, 1'b0, 1'b1, 8'd2);
        // Good op after errors: flag clears, counter holds
        op16("good_after", 16'h0002, 1'b1, 16'h0003, 1'b0, 32'h0000_0006, 1'b0, 1'b0, 8'd2);

        // Unsigned 8-bit: FF*FF = FE01 (8 ones -> parity 0); 80*02 = 0100
        op8("u8_ffff", 8'hFF, 8'hFF, 16'hFE01, 1'b0);
        op8("u8_80x2", 8'h80, 8'h02, 16'h0100, 1'b1);

        // Back-to-back: accepts at k=0,3,6; results at k=3,6,9
        bb_a[0] = 16'd2;    bb_b[0] = 16'd3;      bb_exp[0] = 32'h0000_0006;
        bb_a[1] = 16'hFFFE; bb_b[1] = 16'd4;      bb_exp[1] = 32'hFFFF_FFF8;
        bb_a[2] = 16'd100;  bb_b[2] = 16'hFF9C;   bb_exp[2] = 32'hFFFF_D8F0;
        a = bb_a[0]; ap = ^bb_a[0]; b = bb_b[0]; bp = ^bb_b[0]; req = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk($sformatf("b2b ack k=%0d", k), ack, ((k % 3) == 0) && (k <= 6));
            chk($sformatf("b2b rdy k=%0d", k), rdy, ((k % 3) == 0) && (k >= 3));
            if (((k % 3) == 0) && (k >= 3)) begin
                chk($sformatf("b2b result k=%0d", k), res, bb_exp[k/3 - 1]);
                chk($sformatf("b2b rpar k=%0d", k), rpar, ^bb_exp[k/3 - 1]);
            end
            if ((k % 3) == 0) req = 1'b0;
            if (k == 2 || k == 5) begin
                a = bb_a[k/3 + 1]; ap = ^bb_a[k/3 + 1];
                b = bb_b[k/3 + 1]; bp = ^bb_b[k/3 + 1];
                req = 1'b1;
            end
        end
        @(negedge clk);
        chk("b2b rdy_end", rdy, 1'b0);

        // req held high after ack: no second accept until req is seen low
        a = 16'd1; ap = 1'b1; b = 16'd1; bp = 1'b1; req = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk($sformatf("hold ack k=%0d", k), ack, k == 0);
            chk($sformatf("hold state k=%0d", k), st, (k == 0) ? HS_ACK : HS_WAIT_LOW);
        end
        req = 1'b0;
        @(negedge clk);
        chk("hold back_idle", st, HS_IDLE);
        req = 1'b1;
        @(negedge clk);
        chk("hold reaccept", ack, 1'b1);
        req = 1'b0;
        repeat (4) @(negedge clk);

        // 2-bit error counter saturates at 3 (A=1 with parity 0 is wrong)
        opc("sat1", 16'd1, 1'b0, 16'd1, 1'b1, 2'd1);
        opc("sat2", 16'd1, 1'b0, 16'd1, 1'b1, 2'd2);
        opc("sat3", 16'd1, 1'b0, 16'd1, 1'b1, 2'd3);
        opc("sat4", 16'd1, 1'b0, 16'd1, 1'b1, 2'd3);
        opc("sat5", 16'd1, 1'b0, 16'd1, 1'b1, 2'd3);

        // Reset one cycle after an accept kills the op and clears the counter
        ac = 16'd1; apc = 1'b0; bc = 16'd1; bpc = 1'b1; reqc = 1'b1;
        @(negedge clk);
        chk("rstmid ack", ackc, 1'b1);
        reqc = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid cnt", cntc, 2'd0);
        chk("rstmid ack_clr", ackc, 1'b0);
        chk("rstmid state", stc, HS_IDLE);
        @(negedge clk);
        rst = 1'b0;
        // 5 * 6 = 30 = 0x1E (4 ones -> parity 0), req high at first edge after release
        ac = 16'd5; apc = 1'b0; bc = 16'd6; bpc = 1'b0; reqc = 1'b1;
        @(negedge clk);
        chk("post_rst ack", ackc, 1'b1);
        chk("post_rst rdy0", rdyc, 1'b0);
        reqc = 1'b0;
        @(negedge clk);
        chk("post_rst rdy1", rdyc, 1'b0);
        @(negedge clk);
        chk("post_rst rdy2", rdyc, 1'b0);
        @(negedge clk);
        chk("post_rst rdy", rdyc, 1'b1);
        chk("post_rst result", resc, 32'd30);
        chk("post_rst rpar", rparc, 1'b0);
        chk("post_rst perr", perrc, 1'b0);
        chk("post_rst cnt", cntc, 2'd0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_mult_par_pipe
